i2s_tx: RTL and testbench

I2S master transmitter: accepts parallel left/right PCM sample pairs through a valid/ready handshake and serializes them in standard I2S format. It generates BCK and LRCK from the master clock. It is the source side of the I2S link that our receiver/deserializer front end consumes, and it also drives test streams into the AD1860 path from on-chip sources. All outputs are registered in the `mck_i` domain.

---
 rtl/i2s_tx_if.sv | 23 ++
 rtl/i2s_tx.sv | 129 ++++++++++++
 tb/tb_i2s_tx.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between a PCM source and the I2S transmitter.
interface i2s_tx_if #(
  parameter int unsigned FRAME = 24
) ();
  logic [FRAME-1:0] l_data_i;
  logic [FRAME-1:0] r_data_i;
  logic             valid_i;
  logic             ready_o;

  modport master (
    output l_data_i,
    output r_data_i,
    output valid_i,
    input  ready_o
  );

  modport slave (
    input  l_data_i,
    input  r_data_i,
    input  valid_i,
    output ready_o
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S master transmitter: buffers one L/R pair and serializes it MSB first with the I2S one-bit delay.
// Build option I2S_TX_REPEAT_EN: on underrun repeat the last pair instead of sending silence.
module i2s_tx #(
  parameter int unsigned FRAME   = 24,
  parameter int unsigned SLOT    = 32,
  parameter int unsigned MCK_DIV = 4
) (
  input  logic    mck_i,
  input  logic    rst_i,
  i2s_tx_if.slave smp,
  output logic    bck_o,
  output logic    lrck_o,
  output logic    data_o,
  output logic    underrun_o
);

  localparam int unsigned DIV_W = (MCK_DIV > 1) ? $clog2(MCK_DIV) : 1;
  localparam int unsigned POS_W = $clog2(2 * SLOT);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCK_DIV / 2);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * SLOT - 1);
  localparam logic [POS_W-1:0] SLOT_P   = POS_W'(SLOT);
  localparam logic [POS_W-1:0] FRAME_P  = POS_W'(FRAME);

  logic [DIV_W-1:0] div_cnt;
  logic [POS_W-1:0] pos;
  logic             full;
  logic             ready_q;
  logic [FRAME-1:0] buf_l;
  logic [FRAME-1:0] buf_r;
  logic [FRAME-1:0] sh_l;
  logic [FRAME-1:0] sh_r;

  logic             hs_c;
  logic             fall_c;
  logic             load_c;
  logic             right_c;
  logic             active_c;
  logic             full_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic [POS_W-1:0] k_c;

  assign smp.ready_o = ready_q;

  // Next-state terms: divider wrap is the BCK falling edge, position and slot bit index follow it.
  always_comb begin
    hs_c     = smp.valid_i & ready_q;
    fall_c   = (div_cnt == DIV_LAST);
    div_nxt  = fall_c ? '0 : div_cnt + DIV_W'(1);
    pos_nxt  = pos;
    if (fall_c) begin
      pos_nxt = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
    end
    load_c   = fall_c && (pos_nxt == '0);
    right_c  = (pos_nxt >= SLOT_P);
    k_c      = right_c ? pos_nxt - SLOT_P : pos_nxt;
    active_c = fall_c && (k_c != '0) && (k_c <= FRAME_P);
    // A load frees the buffer before a same-edge handshake refills it for the next frame.
    full_nxt = full;
    if (load_c) begin
      full_nxt = 1'b0;
    end
    if (hs_c) begin
      full_nxt = 1'b1;
    end
  end

  always_ff @(posedge mck_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt    <= '0;
      pos        <= POS_LAST;
      full       <= 1'b0;
      ready_q    <= 1'b0;
      buf_l      <= '0;
      buf_r      <= '0;
      sh_l       <= '0;
      sh_r       <= '0;
      bck_o      <= 1'b0;
      lrck_o     <= 1'b1;
      data_o     <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      bck_o      <= (div_nxt >= DIV_HALF);
      full       <= full_nxt;
      ready_q    <= ~full_nxt;
      underrun_o <= 1'b0;

      if (hs_c) begin
        buf_l <= smp.l_data_i;
        buf_r <= smp.r_data_i;
      end

      if (fall_c) begin
        pos    <= pos_nxt;
        lrck_o <= right_c;
        data_o <= 1'b0;
      end

      // Rotate rather than shift so a full slot leaves the sample intact for repeats.
      if (active_c) begin
        if (right_c) begin
          data_o <= sh_r[FRAME-1];
          sh_r   <= {sh_r[FRAME-2:0], sh_r[FRAME-1]};
        end else begin
          data_o <= sh_l[FRAME-1];
          sh_l   <= {sh_l[FRAME-2:0], sh_l[FRAME-1]};
        end
      end

      if (load_c) begin
        if (full) begin
          sh_l <= buf_l;
          sh_r <= buf_r;
        end else begin
          underrun_o <= 1'b1;
`ifdef I2S_TX_REPEAT_EN
`else
          sh_l <= '0;
          sh_r <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: two configurations against a frame-level reference model.
module tb_i2s_tx;

  localparam int SLOT = 32;

  logic mck = 1'b0;
  logic rst;
  always #5 mck = ~mck;

  logic        v  [2];
  logic [23:0] sl [2];
  logic [23:0] sr [2];
  logic [1:0]  bck_w, lrck_w, data_w, urun_w, rdy_w;

  i2s_tx_if #(.FRAME(24)) if0 ();
  i2s_tx_if #(.FRAME(16)) if1 ();

  assign if0.l_data_i = sl[0];
  assign if0.r_data_i = sr[0];
  assign if0.valid_i  = v[0];
  assign if1.l_data_i = sl[1][15:0];
  assign if1.r_data_i = sr[1][15:0];
  assign if1.valid_i  = v[1];
  assign rdy_w        = {if1.ready_o, if0.ready_o};

  i2s_tx #(.FRAME(24), .SLOT(32), .MCK_DIV(4)) u_dut0 (
    .mck_i(mck), .rst_i(rst), .smp(if0),
    .bck_o(bck_w[0]), .lrck_o(lrck_w[0]), .data_o(data_w[0]), .underrun_o(urun_w[0])
  );

  i2s_tx #(.FRAME(16), .SLOT(32), .MCK_DIV(8)) u_dut1 (
    .mck_i(mck), .rst_i(rst), .smp(if1),
    .bck_o(bck_w[1]), .lrck_o(lrck_w[1]), .data_o(data_w[1]), .underrun_o(urun_w[1])
  );

  int n_chk;
  int n_err;
  int t;

  bit          m_full [2];
  bit          m_rdy  [2];
  bit          m_urun [2];
  bit          m_acc  [2];
  logic [23:0] m_bl [2];
  logic [23:0] m_br [2];
  logic [23:0] m_cl [2];
  logic [23:0] m_cr [2];

  int          hs_cnt   [2];
  int          urun_cnt [2];
  int          ff       [2];
  logic        lr_prev  [2];
  logic        bck_prev [2];
  logic [23:0] nv       [2];
  bit          streaming;
  bit          cap_en;
  int          rise_n;
  logic [31:0] cap_l;
  logic [31:0] cap_r;

  function automatic int frame_of(input int i);
    return (i == 0) ? 24 : 16;
  endfunction

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0d time=%0t", tag, got, exp, t, $time);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0; m_rdy[i] = 0; m_urun[i] = 0; m_acc[i] = 0;
      m_bl[i] = '0; m_br[i] = '0; m_cl[i] = '0; m_cr[i] = '0;
      lr_prev[i] = 1'b1; bck_prev[i] = 1'b0; ff[i] = 0;
    end
  endtask

  // Frame-level view: a load every 2*SLOT bit periods, starting one bit period after reset release.
  task automatic model_edge(input int i);
    int d, b;
    bit ld;
    logic [23:0] msk;
    d   = div_of(i);
    b   = t / d;
    msk = (i == 0) ? 24'hFFFFFF : 24'h00FFFF;
    ld  = (t % d == 0) && (b >= 1) && (((b - 1) % (2 * SLOT)) == 0);
    m_acc[i]  = v[i] && m_rdy[i];
    m_urun[i] = 0;
    if (ld) begin
      if (streaming) begin
        check_val($sformatf("stream_acc_per_frame%0d", i), 32'(hs_cnt[i]), 32'd1);
        hs_cnt[i] = 0;
      end
      if (m_full[i]) begin
        m_cl[i] = m_bl[i]; m_cr[i] = m_br[i]; m_full[i] = 0;
      end else begin
        m_urun[i] = 1;
`ifndef I2S_TX_REPEAT_EN
        m_cl[i] = '0; m_cr[i] = '0;
`endif
      end
    end
    if (m_acc[i]) begin
      m_bl[i] = sl[i] & msk; m_br[i] = sr[i] & msk; m_full[i] = 1;
    end
    m_rdy[i] = !m_full[i];
  endtask

  task automatic compare(input int i);
    int d, f, b, pos, k;
    logic lr, e_data;
    d   = div_of(i);
    f   = frame_of(i);
    b   = t / d;
    pos = (b == 0) ? 2 * SLOT - 1 : (b - 1) % (2 * SLOT);
    lr  = (pos >= SLOT);
    k   = pos % SLOT;
    e_data = 1'b0;
    if (k >= 1 && k <= f) e_data = lr ? m_cr[i][f-k] : m_cl[i][f-k];
    check_val($sformatf("bck%0d", i),      32'(bck_w[i]),  32'((t % d) >= d / 2));
    check_val($sformatf("lrck%0d", i),     32'(lrck_w[i]), 32'(lr));
    check_val($sformatf("data%0d", i),     32'(data_w[i]), 32'(e_data));
    check_val($sformatf("ready%0d", i),    32'(rdy_w[i]),  32'(m_rdy[i]));
    check_val($sformatf("underrun%0d", i), 32'(urun_w[i]), 32'(m_urun[i]));
    if (!rst && lr_prev[i] && !lrck_w[i] && ff[i] == 0) ff[i] = t;
    lr_prev[i] = lrck_w[i];
    if (i == 0 && cap_en && !bck_prev[0] && bck_w[0] && ff[0] != 0 && rise_n < 64) begin
      if (rise_n < 32) cap_l = {cap_l[30:0], data_w[0]};
      else             cap_r = {cap_r[30:0], data_w[0]};
      rise_n++;
    end
    bck_prev[i] = bck_w[i];
    urun_cnt[i] += int'(urun_w[i]);
  endtask

  task automatic step();
    for (int i = 0; i < 2; i++) if (v[i] && rdy_w[i]) hs_cnt[i]++;
    @(posedge mck);
    if (!rst) begin
      t++;
      for (int i = 0; i < 2; i++) model_edge(i);
    end
    #1;
    for (int i = 0; i < 2; i++) compare(i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    n_chk = 0; n_err = 0; streaming = 0; cap_en = 0; rise_n = 0;
    cap_l = '0; cap_r = '0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; sl[i] = '0; sr[i] = '0; hs_cnt[i] = 0; urun_cnt[i] = 0; nv[i] = '0;
    end
    rst = 1'b1;
    model_reset();
    repeat (10) step();
    rst = 1'b0;
    model_reset();

    // Single known pair written before the first load.
    cap_en = 1;
    for (int i = 0; i < 2; i++) begin v[i] = 1'b1; sl[i] = 24'h800001; sr[i] = 24'h7FFFFE; end
    repeat (600) begin
      step();
      for (int i = 0; i < 2; i++) if (m_acc[i]) v[i] = 1'b0;
    end
    cap_en = 0;
    for (int i = 0; i < 2; i++) check_val($sformatf("first_lrck_fall%0d", i), 32'(ff[i]), 32'(div_of(i)));
    check_val("slot_bits_captured", 32'(rise_n), 32'd64);
    check_val("left_slot_bits",  cap_l, 32'h4000_0080);
    check_val("right_slot_bits", cap_r, 32'h3FFF_FF00);

    // Starvation: one underrun per frame.
    for (int i = 0; i < 2; i++) urun_cnt[i] = 0;
    repeat (1024) step();
    check_val("starve_underruns0", 32'(urun_cnt[0]), 32'd4);
    check_val("starve_underruns1", 32'(urun_cnt[1]), 32'd2);

    // Mid-frame reset when the 24-bit instance reaches position 40.
    guard = 0;
    while (!((t % 4 == 0) && (t >= 4) && (((t / 4) - 1) % 64 == 40)) && guard < 600) begin
      step();
      guard++;
    end
    check_val("reach_pos40", 32'(guard < 600), 32'd1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("async_rst_bck%0d", i),  32'(bck_w[i]),  32'd0);
      check_val($sformatf("async_rst_lrck%0d", i), 32'(lrck_w[i]), 32'd1);
      check_val($sformatf("async_rst_data%0d", i), 32'(data_w[i]), 32'd0);
      check_val($sformatf("async_rst_rdy%0d", i),  32'(rdy_w[i]),  32'd0);
      check_val($sformatf("async_rst_urun%0d", i), 32'(urun_w[i]), 32'd0);
    end
    model_reset();
    repeat (10) step();
    rst = 1'b0;
    model_reset();

    // One pair then starve: repeated or silent depending on the build.
    for (int i = 0; i < 2; i++) begin v[i] = 1'b1; sl[i] = 24'h123456; sr[i] = 24'hABCDEF; end
    repeat (1100) begin
      step();
      for (int i = 0; i < 2; i++) if (m_acc[i]) v[i] = 1'b0;
    end
    for (int i = 0; i < 2; i++) check_val($sformatf("rst2_first_lrck_fall%0d", i), 32'(ff[i]), 32'(div_of(i)));

    // Streaming incrementing pairs with valid held high.
    guard = 0;
    while ((t % 256) != 100 && guard < 300) begin step(); guard++; end
    streaming = 1;
    nv[0] = 24'($urandom);
    nv[1] = nv[0];
    for (int i = 0; i < 2; i++) begin
      hs_cnt[i] = 0; urun_cnt[i] = 0; v[i] = 1'b1; sl[i] = nv[i]; sr[i] = ~nv[i];
    end
    repeat (1600) begin
      step();
      for (int i = 0; i < 2; i++) if (m_acc[i]) begin
        nv[i] = nv[i] + 24'd1; sl[i] = nv[i]; sr[i] = ~nv[i];
      end
    end
    streaming = 0;
    check_val("stream_underruns0", 32'(urun_cnt[0]), 32'd0);
    check_val("stream_underruns1", 32'(urun_cnt[1]), 32'd0);

    // Random traffic.
    repeat (1024) begin
      for (int i = 0; i < 2; i++) begin
        v[i]  = ($urandom % 3) == 0;
        sl[i] = 24'($urandom);
        sr[i] = 24'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
